bcnt_pwm: RTL

Complementary PWM generator with dead-time insertion, placed directly downstream of the fixed-step binary counter (`bcnts`) running in up/ROLL mode. It compares the counter value against an active duty threshold. Duty updates arrive over a valid/ready handshake into a shadow register and are applied only at the counter's wrap boundary. Output is a glitch-free high-side/low-side pair that is never simultaneously high.

---
 rtl/bcnt_pwm.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/bcnt_pwm.sv
// rtl/bcnt_pwm.sv - complementary dead-time PWM driven from an up/ROLL bcnts counter
//
// Purpose:
//   Compares the upstream counter value against an active duty threshold and
//   drives a high-side/low-side output pair that is never high at the same
//   time. Between the two drive phases both outputs are held low for DEADTIME
//   cycles. Duty updates arrive over a valid/ready handshake into a shadow
//   register. They become active only at the counter wrap, so each period is
//   generated with a single, consistent threshold.
//
// Ports:
//   clk         sole clock, rising edge
//   sclr        synchronous active-high reset, overrides everything
//   en          output enable; low forces both outputs low
//   cnt_q       counter value from bcnts
//   cnt_ovf     counter terminal flag (cnt_q == MAX)
//   cnt_ena     counter enable, the same one that drives bcnts
//   duty        requested high-demand count per period, 0..2^WIDTH
//   duty_valid  duty is valid
//   duty_ready  shadow register is free
//   upd         one-cycle pulse when a new duty becomes active
//   pwm_h       high-side drive
//   pwm_l       low-side drive

module bcnt_pwm #(
  parameter int MAX       = 255,
  parameter int WIDTH     = $clog2(MAX + 1),
  parameter int DEADTIME  = 2,
  parameter int INIT_DUTY = 0
) (
  input  logic             clk,
  input  logic             sclr,
  input  logic             en,
  input  logic [WIDTH-1:0] cnt_q,
  input  logic             cnt_ovf,
  input  logic             cnt_ena,
  input  logic [WIDTH:0]   duty,
  input  logic             duty_valid,
  output logic             duty_ready,
  output logic             upd,
  output logic             pwm_h,
  output logic             pwm_l
);

  localparam logic [2:0] ST_OFF     = 3'd0;
  localparam logic [2:0] ST_LOW     = 3'd1;
  localparam logic [2:0] ST_DEAD_LH = 3'd2;
  localparam logic [2:0] ST_HIGH    = 3'd3;
  localparam logic [2:0] ST_DEAD_HL = 3'd4;

  // The dead counter holds DEADTIME-1 at most; keep it at least one bit wide
  // so DEADTIME of 0 or 1 still elaborates.
  localparam int              DW       = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;
  localparam logic [DW-1:0]   DT_LOAD  = DW'((DEADTIME > 0) ? DEADTIME - 1 : 0);
  localparam logic [WIDTH:0]  INIT_ACT = (WIDTH + 1)'(INIT_DUTY);

  logic [2:0]      state_q, state_d;
  logic [DW-1:0]   dcnt_q, dcnt_d;
  logic            dem_q, dem_d;
  logic            pending_q, pending_d;
  logic [WIDTH:0]  shadow_q, shadow_d;
  logic [WIDTH:0]  duty_act_q, duty_act_d;
  logic            upd_q, upd_d;
  logic            pwm_h_q, pwm_h_d;
  logic            pwm_l_q, pwm_l_d;

  logic            bnd;
  logic            accept;
  logic            apply;

  assign bnd        = cnt_ena & cnt_ovf;
  assign duty_ready = ~pending_q & ~sclr;
  assign accept     = duty_valid & duty_ready;
  // Only a value already sitting in the shadow register can be applied, so a
  // duty accepted in the wrap cycle waits for the following wrap.
  assign apply      = bnd & pending_q;

  // Duty handshake, boundary apply and demand compare.
  always_comb begin
    shadow_d   = shadow_q;
    pending_d  = pending_q;
    duty_act_d = duty_act_q;
    upd_d      = apply;
    if (apply) begin
      duty_act_d = shadow_q;
      pending_d  = 1'b0;
    end
    if (accept) begin
      shadow_d  = duty;
      pending_d = 1'b1;
    end
    // Zero-extend the counter so duty_act == 2^WIDTH yields 100 % demand.
    dem_d = en & ({1'b0, cnt_q} < duty_act_q);
  end

  // Output state machine. Dead phases abort back to the side that was driving
  // if demand flips back before the dead band expires.
  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    if (!en) begin
      state_d = ST_OFF;
    end else begin
      case (state_q)
        ST_OFF: begin
          // Both outputs are already low, so no dead band is needed here.
          state_d = dem_q ? ST_HIGH : ST_LOW;
        end
        ST_LOW: begin
          if (dem_q) begin
            if (DEADTIME == 0) begin
              state_d = ST_HIGH;
            end else begin
              state_d = ST_DEAD_LH;
              dcnt_d  = DT_LOAD;
            end
          end
        end
        ST_DEAD_LH: begin
          if (!dem_q) begin
            state_d = ST_LOW;
          end else if (dcnt_q == '0) begin
            state_d = ST_HIGH;
          end else begin
            dcnt_d = dcnt_q - DW'(1);
          end
        end
        ST_HIGH: begin
          if (!dem_q) begin
            if (DEADTIME == 0) begin
              state_d = ST_LOW;
            end else begin
              state_d = ST_DEAD_HL;
              dcnt_d  = DT_LOAD;
            end
          end
        end
        ST_DEAD_HL: begin
          if (dem_q) begin
            state_d = ST_HIGH;
          end else if (dcnt_q == '0) begin
            state_d = ST_LOW;
          end else begin
            dcnt_d = dcnt_q - DW'(1);
          end
        end
        default: begin
          state_d = ST_OFF;
        end
      endcase
    end
    // Outputs are flops loaded from the next state so they never glitch
    // through a combinational state decode.
    pwm_h_d = (state_d == ST_HIGH);
    pwm_l_d = (state_d == ST_LOW);
  end

  always_ff @(posedge clk) begin
    if (sclr) begin
      state_q    <= ST_OFF;
      dcnt_q     <= '0;
      dem_q      <= 1'b0;
      pending_q  <= 1'b0;
      shadow_q   <= '0;
      duty_act_q <= INIT_ACT;
      upd_q      <= 1'b0;
      pwm_h_q    <= 1'b0;
      pwm_l_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      dcnt_q     <= dcnt_d;
      dem_q      <= dem_d;
      pending_q  <= pending_d;
      shadow_q   <= shadow_d;
      duty_act_q <= duty_act_d;
      upd_q      <= upd_d;
      pwm_h_q    <= pwm_h_d;
      pwm_l_q    <= pwm_l_d;
    end
  end

  assign upd   = upd_q;
  assign pwm_h = pwm_h_q;
  assign pwm_l = pwm_l_q;

endmodule
